// File: rtl/sram_word_bridge.sv
// CPU load/store to 128-bit line bridge for the SRAM master port; one request in flight.
// Optional one-line read buffer enabled by defining SRAM_WORD_BRIDGE_LINEBUF_EN.
module sram_word_bridge #(
  parameter int ADDR_W = 32,
  parameter int LINE_B = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [1:0]            i_req_size,
  input  logic [ADDR_W-1:0]     i_req_addr,
  input  logic [31:0]           i_req_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [31:0]           o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic [ADDR_W-1:0]     o_readAddr_addr,
  output logic                  o_readAddr_valid,
  input  logic                  i_readAddr_ready,
  input  logic [8*LINE_B-1:0]   i_readData_data,
  input  logic                  i_readData_valid,
  output logic                  o_readData_ready,
  output logic [ADDR_W-1:0]     o_writeAddr_addr,
  output logic                  o_writeAddr_valid,
  input  logic                  i_writeAddr_ready,
  output logic [8*LINE_B-1:0]   o_writeData_data,
  output logic [LINE_B-1:0]     o_writeData_strb,
  output logic                  o_writeData_valid,
  input  logic                  i_writeData_ready,
  input  logic [31:0]           i_writeResp_msg,
  input  logic                  i_writeResp_valid,
  output logic                  o_writeResp_ready
);

  localparam int DATA_W = 8 * LINE_B;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RADDR = 3'd1,
    S_RDATA = 3'd2,
    S_WREQ  = 3'd3,
    S_WRESP = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_size;
  logic [31:0]         r_wdata;
  logic                r_aw_done;
  logic                r_w_done;
  logic [31:0]         r_rsp_rdata;
  logic                r_rsp_err;
  logic                w_req_bad;
  logic                w_hit;
  logic [DATA_W-1:0]   w_lb_line;

  function automatic logic [3:0] f_size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 4'h1;
      2'd1:    return 4'h3;
      2'd2:    return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return lo[0];
      2'd2:    return |lo;
      default: return 1'b1;
    endcase
  endfunction

  // Aligned requests never cross the line, so the low 32 bits after the shift hold every byte.
  function automatic logic [31:0] f_extract(input logic [DATA_W-1:0] line,
                                            input logic [3:0] off,
                                            input logic [1:0] size);
    logic [31:0] w;
    w = 32'(line >> {off, 3'b000});
    case (size)
      2'd0:    return {24'h000000, w[7:0]};
      2'd1:    return {16'h0000, w[15:0]};
      2'd2:    return w;
      default: return 32'h00000000;
    endcase
  endfunction

  assign w_req_bad = f_misaligned(i_req_size, i_req_addr[1:0]);

`ifdef SRAM_WORD_BRIDGE_LINEBUF_EN
  logic                r_lb_valid;
  logic [ADDR_W-5:0]   r_lb_tag;
  logic [DATA_W-1:0]   r_lb_data;

  function automatic logic [DATA_W-1:0] f_merge(input logic [DATA_W-1:0] old_line,
                                                input logic [DATA_W-1:0] new_line,
                                                input logic [LINE_B-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_line;
    for (int i = 0; i < LINE_B; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_line[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_line[8*i +: 8];
      end
    end
    return res;
  endfunction

  assign w_hit     = r_lb_valid && (r_lb_tag == i_req_addr[ADDR_W-1:4]);
  assign w_lb_line = r_lb_data;

  // Line buffer: fill on every bus read, merge successful stores that hit it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lb_valid <= 1'b0;
      r_lb_tag   <= '0;
      r_lb_data  <= '0;
    end else if (r_state == S_RDATA && i_readData_valid) begin
      r_lb_valid <= 1'b1;
      r_lb_tag   <= r_addr[ADDR_W-1:4];
      r_lb_data  <= i_readData_data;
    end else if (r_state == S_WRESP && i_writeResp_valid && i_writeResp_msg == 32'h0 &&
                 r_lb_valid && r_lb_tag == r_addr[ADDR_W-1:4]) begin
      r_lb_data  <= f_merge(r_lb_data, o_writeData_data, o_writeData_strb);
    end
  end
`else
  assign w_hit     = 1'b0;
  assign w_lb_line = '0;
`endif

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          if (w_req_bad)     w_state_nxt = S_RESP;
          else if (i_req_we) w_state_nxt = S_WREQ;
          else if (w_hit)    w_state_nxt = S_RESP;
          else               w_state_nxt = S_RADDR;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RADDR: w_state_nxt = i_readAddr_ready  ? S_RDATA : S_RADDR;
      S_RDATA: w_state_nxt = i_readData_valid  ? S_RESP  : S_RDATA;
      S_WREQ:  w_state_nxt = ((r_aw_done || i_writeAddr_ready) && (r_w_done || i_writeData_ready))
                             ? S_WRESP : S_WREQ;
      S_WRESP: w_state_nxt = i_writeResp_valid ? S_RESP  : S_WRESP;
      S_RESP:  w_state_nxt = i_rsp_ready       ? S_IDLE  : S_RESP;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register plus request latch, write-handshake flags and response capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_size      <= 2'd0;
      r_wdata     <= 32'h0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_addr      <= i_req_addr;
            r_size      <= i_req_size;
            r_wdata     <= i_req_wdata;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_rsp_err   <= w_req_bad;
            r_rsp_rdata <= (w_hit && !w_req_bad && !i_req_we)
                           ? f_extract(w_lb_line, i_req_addr[3:0], i_req_size) : 32'h0;
          end
        end
        S_RDATA: begin
          if (i_readData_valid) begin
            r_rsp_rdata <= f_extract(i_readData_data, r_addr[3:0], r_size);
          end
        end
        S_WREQ: begin
          if (i_writeAddr_ready) r_aw_done <= 1'b1;
          if (i_writeData_ready) r_w_done  <= 1'b1;
        end
        S_WRESP: begin
          if (i_writeResp_valid) r_rsp_err <= (i_writeResp_msg != 32'h0);
        end
        default: ;
      endcase
    end
  end

  assign o_req_ready       = (r_state == S_IDLE);
  assign o_readAddr_addr   = {r_addr[ADDR_W-1:4], 4'h0};
  assign o_readAddr_valid  = (r_state == S_RADDR);
  assign o_readData_ready  = (r_state == S_RDATA);
  assign o_writeAddr_addr  = {r_addr[ADDR_W-1:4], 4'h0};
  assign o_writeAddr_valid = (r_state == S_WREQ) && !r_aw_done;
  assign o_writeData_valid = (r_state == S_WREQ) && !r_w_done;
  assign o_writeData_data  = DATA_W'(r_wdata) << {r_addr[3:0], 3'b000};
  assign o_writeData_strb  = LINE_B'(f_size_mask(r_size)) << r_addr[3:0];
  assign o_writeResp_ready = (r_state == S_WRESP);
  assign o_rsp_valid       = (r_state == S_RESP);
  assign o_rsp_rdata       = r_rsp_rdata;
  assign o_rsp_err         = r_rsp_err;

endmodule

// File: tb/tb_sram_word_bridge.sv
// Bench for sram_word_bridge: directed and random loads/stores against a byte-array memory model
// and a line-organised SRAM slave.
module tb_sram_word_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_req_valid, i_req_we;
  logic [1:0]   i_req_size;
  logic [31:0]  i_req_addr, i_req_wdata;
  logic         o_req_ready;
  logic         o_rsp_valid, i_rsp_ready, o_rsp_err;
  logic [31:0]  o_rsp_rdata;
  logic [31:0]  o_readAddr_addr, o_writeAddr_addr, i_writeResp_msg;
  logic         o_readAddr_valid, i_readAddr_ready;
  logic [127:0] i_readData_data, o_writeData_data;
  logic         i_readData_valid, o_readData_ready;
  logic         o_writeAddr_valid, i_writeAddr_ready;
  logic [15:0]  o_writeData_strb;
  logic         o_writeData_valid, i_writeData_ready;
  logic         i_writeResp_valid, o_writeResp_ready;

  always #5 clk = ~clk;

  sram_word_bridge dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
    .i_req_size(i_req_size), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_err(o_rsp_err),
    .o_readAddr_addr(o_readAddr_addr), .o_readAddr_valid(o_readAddr_valid),
    .i_readAddr_ready(i_readAddr_ready),
    .i_readData_data(i_readData_data), .i_readData_valid(i_readData_valid),
    .o_readData_ready(o_readData_ready),
    .o_writeAddr_addr(o_writeAddr_addr), .o_writeAddr_valid(o_writeAddr_valid),
    .i_writeAddr_ready(i_writeAddr_ready),
    .o_writeData_data(o_writeData_data), .o_writeData_strb(o_writeData_strb),
    .o_writeData_valid(o_writeData_valid), .i_writeData_ready(i_writeData_ready),
    .i_writeResp_msg(i_writeResp_msg), .i_writeResp_valid(i_writeResp_valid),
    .o_writeResp_ready(o_writeResp_ready)
  );

`ifdef SRAM_WORD_BRIDGE_LINEBUF_EN
  localparam bit LB_EN = 1'b1;
`else
  localparam bit LB_EN = 1'b0;
`endif

  logic [7:0]   ref_mem  [0:65535];
  logic [127:0] slv_line [0:4095];
  bit           lb_valid;
  logic [27:0]  lb_tag;
  int           nvec = 0;
  int           nfail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input int ar_stall, input int w_stall,
                         input logic [31:0] bmsg, input bit abort);
    bit bad, hit, exp_bus, bus_seen, done, rsp_seen, b_sent;
    bit ar_f, r_f, aw_f, w_f, b_f, rsp_f, rd_pend, aw_done, w_done;
    int nb, off, cyc, rsp_wait;
    logic [31:0]  exp_rdata, line_addr, p_araddr, p_rdata, aw_cap;
    logic         exp_err, p_arv, p_awv, p_wv, p_rspv, p_err;
    logic [15:0]  exp_strb, p_strb, w_strb_c;
    logic [127:0] exp_wdata, p_wdata, w_data_c;
    logic [11:0]  ar_idx;

    bad = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    nb = 1 << size;
    off = int'(addr[3:0]);
    line_addr = {addr[31:4], 4'h0};
    hit = !bad && !we && lb_valid && (lb_tag == addr[31:4]);
    exp_bus = !bad && !hit;
    exp_err = bad || (we && bmsg != 32'h0);
    exp_rdata = 32'h0;
    if (!bad && !we) for (int i = 0; i < nb; i++) exp_rdata[8*i +: 8] = ref_mem[int'(addr[15:0]) + i];
    exp_strb = 16'(((1 << nb) - 1) << off);
    exp_wdata = 128'(wdata) << (8 * off);

    @(negedge clk);
    chk("req_ready_idle", o_req_ready, 1'b1);
    i_req_valid = 1'b1; i_req_we = we; i_req_size = size; i_req_addr = addr; i_req_wdata = wdata;
    @(negedge clk);
    i_req_valid = 1'b0;
    {bus_seen, done, rsp_seen, b_sent, ar_f, r_f, aw_f, w_f, b_f, rsp_f, rd_pend, aw_done, w_done} = '0;
    {p_arv, p_awv, p_wv, p_rspv, p_err} = '0;
    p_araddr = '0; p_rdata = '0; p_strb = '0; p_wdata = '0; w_strb_c = '0; w_data_c = '0;
    aw_cap = '0; ar_idx = '0; cyc = 0; rsp_wait = 0;

    while (!done && cyc < 200) begin
      if (rsp_f) begin
        i_rsp_ready = 1'b0;
        chk("rsp_drop", o_rsp_valid, 1'b0);
        chk("req_ready_after", o_req_ready, 1'b1);
        done = 1'b1;
      end else if (abort && o_writeResp_ready) begin
        rst = 1'b1;
        #1;
        chk("abort_arvalid", o_readAddr_valid, 1'b0);
        chk("abort_awvalid", o_writeAddr_valid, 1'b0);
        chk("abort_wvalid", o_writeData_valid, 1'b0);
        chk("abort_bready", o_writeResp_ready, 1'b0);
        chk("abort_req_ready", o_req_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
          @(negedge clk);
          chk("abort_no_rsp", o_rsp_valid, 1'b0);
          chk("abort_idle", o_req_ready, 1'b1);
        end
        done = 1'b1;
      end else begin
        if (o_readAddr_valid | o_readData_ready | o_writeAddr_valid | o_writeData_valid | o_writeResp_ready)
          bus_seen = 1'b1;
        if (ar_f) begin rd_pend = 1'b1; i_readData_data = slv_line[ar_idx]; end
        if (r_f) begin rd_pend = 1'b0; i_readData_valid = 1'b0; end
        if (aw_f) aw_done = 1'b1;
        if (w_f) w_done = 1'b1;
        if (b_f) i_writeResp_valid = 1'b0;
        if (p_arv && !ar_f) begin
          chk("ar_hold", o_readAddr_valid, 1'b1);
          chk("ar_addr_stable", o_readAddr_addr, p_araddr);
        end
        if (p_awv && !aw_f) chk("aw_hold", o_writeAddr_valid, 1'b1);
        if (p_wv && !w_f) begin
          chk("w_hold", o_writeData_valid, 1'b1);
          chk("w_data_stable", o_writeData_data, p_wdata);
          chk("w_strb_stable", o_writeData_strb, p_strb);
        end
        if (p_rspv) begin
          chk("rsp_hold", o_rsp_valid, 1'b1);
          chk("rsp_rdata_stable", o_rsp_rdata, p_rdata);
          chk("rsp_err_stable", o_rsp_err, p_err);
        end
        i_readAddr_ready  = (cyc >= ar_stall);
        i_writeAddr_ready = 1'b1;
        i_writeData_ready = (cyc >= w_stall);
        if (rd_pend) i_readData_valid = 1'b1;
        if (aw_done && w_done && !b_sent && !abort) begin
          i_writeResp_valid = 1'b1; i_writeResp_msg = bmsg; b_sent = 1'b1;
        end
        if (o_rsp_valid && !rsp_seen) begin
          rsp_seen = 1'b1;
          chk("rsp_rdata", o_rsp_rdata, exp_rdata);
          chk("rsp_err", o_rsp_err, exp_err);
          if (hit) chk("hit_latency", cyc, 0);
          rsp_wait = $urandom_range(0, 2);
        end
        i_rsp_ready = o_rsp_valid && (rsp_wait == 0);
        if (o_rsp_valid && rsp_wait > 0) rsp_wait--;

        ar_f = o_readAddr_valid && i_readAddr_ready;
        if (ar_f) begin chk("ar_addr", o_readAddr_addr, line_addr); ar_idx = o_readAddr_addr[15:4]; end
        r_f = i_readData_valid && o_readData_ready;
        aw_f = o_writeAddr_valid && i_writeAddr_ready;
        if (aw_f) begin chk("aw_addr", o_writeAddr_addr, line_addr); aw_cap = o_writeAddr_addr; end
        w_f = o_writeData_valid && i_writeData_ready;
        if (w_f) begin
          chk("w_strb", o_writeData_strb, exp_strb);
          chk("w_data", o_writeData_data, exp_wdata);
          w_strb_c = o_writeData_strb; w_data_c = o_writeData_data;
        end
        b_f = i_writeResp_valid && o_writeResp_ready;
        if (b_f && bmsg == 32'h0)
          for (int b = 0; b < 16; b++)
            if (w_strb_c[b]) slv_line[aw_cap[15:4]][8*b +: 8] = w_data_c[8*b +: 8];
        rsp_f = o_rsp_valid && i_rsp_ready;
        p_arv = o_readAddr_valid; p_araddr = o_readAddr_addr; p_awv = o_writeAddr_valid;
        p_wv = o_writeData_valid; p_wdata = o_writeData_data; p_strb = o_writeData_strb;
        p_rspv = o_rsp_valid && !i_rsp_ready; p_rdata = o_rsp_rdata; p_err = o_rsp_err;
        @(negedge clk);
        cyc++;
      end
    end
    chk("txn_complete", done, 1'b1);
    chk("bus_traffic", bus_seen, exp_bus);
    if (abort) begin
      lb_valid = 1'b0;
    end else begin
      if (we && !bad && bmsg == 32'h0)
        for (int i = 0; i < nb; i++) ref_mem[int'(addr[15:0]) + i] = wdata[8*i +: 8];
      if (LB_EN && !we && !bad && !hit) begin lb_valid = 1'b1; lb_tag = addr[31:4]; end
    end
    i_readAddr_ready = 1'b0; i_readData_valid = 1'b0; i_writeAddr_ready = 1'b0;
    i_writeData_ready = 1'b0; i_writeResp_valid = 1'b0; i_rsp_ready = 1'b0;
  endtask

  logic        r_we;
  logic [1:0]  r_sz;
  logic [31:0] r_ad, r_wd, r_msg;

  initial begin
    rst = 1'b1;
    i_req_valid = 1'b0; i_req_we = 1'b0; i_req_size = 2'd0; i_req_addr = 32'h0; i_req_wdata = 32'h0;
    i_rsp_ready = 1'b0; i_readAddr_ready = 1'b0; i_readData_data = '0; i_readData_valid = 1'b0;
    i_writeAddr_ready = 1'b0; i_writeData_ready = 1'b0; i_writeResp_msg = 32'h0;
    i_writeResp_valid = 1'b0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'($urandom);
    for (int l = 0; l < 4096; l++)
      for (int b = 0; b < 16; b++) slv_line[l][8*b +: 8] = ref_mem[16*l + b];
    lb_valid = 1'b0; lb_tag = '0;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", o_req_ready, 1'b1);
    chk("rst_arvalid", o_readAddr_valid, 1'b0);
    chk("rst_rready", o_readData_ready, 1'b0);
    chk("rst_awvalid", o_writeAddr_valid, 1'b0);
    chk("rst_wvalid", o_writeData_valid, 1'b0);
    chk("rst_bready", o_writeResp_ready, 1'b0);
    chk("rst_rsp_valid", o_rsp_valid, 1'b0);
    chk("rst_rsp_rdata", o_rsp_rdata, 32'h0);
    chk("rst_rsp_err", o_rsp_err, 1'b0);
    rst = 1'b0;

    run_txn(1'b1, 2'd2, 32'h0104, 32'hDEADBEEF, 0, 0, 32'h0, 1'b0);
    run_txn(1'b0, 2'd2, 32'h0104, 32'h0, 0, 0, 32'h0, 1'b0);
    run_txn(1'b1, 2'd0, 32'h000F, 32'h000000A5, 0, 0, 32'h0, 1'b0);
    run_txn(1'b0, 2'd2, 32'h000C, 32'h0, 0, 0, 32'h0, 1'b0);
    run_txn(1'b0, 2'd1, 32'h0003, 32'h0, 0, 0, 32'h0, 1'b0);
    run_txn(1'b0, 2'd3, 32'h0000, 32'h0, 0, 0, 32'h0, 1'b0);
    run_txn(1'b1, 2'd2, 32'h0300, 32'h12345678, 5, 5, 32'h0, 1'b0);
    run_txn(1'b0, 2'd2, 32'h0300, 32'h0, 5, 5, 32'h0, 1'b0);
    run_txn(1'b1, 2'd1, 32'h0042, 32'h0000BEEF, 0, 0, 32'h2, 1'b0);
    run_txn(1'b0, 2'd1, 32'h0042, 32'h0, 0, 0, 32'h0, 1'b0);
    run_txn(1'b1, 2'd2, 32'h0110, 32'hCAFEF00D, 0, 2, 32'h0, 1'b1);
    run_txn(1'b0, 2'd2, 32'h0200, 32'h0, 0, 0, 32'h0, 1'b0);
    run_txn(1'b0, 2'd2, 32'h0208, 32'h0, 0, 0, 32'h0, 1'b0);
    run_txn(1'b1, 2'd2, 32'h0204, 32'h0BADF00D, 0, 0, 32'h0, 1'b0);
    run_txn(1'b0, 2'd2, 32'h0204, 32'h0, 0, 0, 32'h0, 1'b0);
    run_txn(1'b0, 2'd0, 32'h0207, 32'h0, 0, 0, 32'h0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      r_we = 1'($urandom);
      r_sz = 2'($urandom_range(0, 3));
      r_ad = 32'($urandom_range(0, 32'h03FF));
      if ($urandom_range(0, 3) != 0) r_ad = r_ad & ~((32'h1 << r_sz) - 32'h1);
      r_wd = $urandom;
      r_msg = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 255)) : 32'h0;
      run_txn(r_we, r_sz, r_ad, r_wd, $urandom_range(0, 3), $urandom_range(0, 3), r_msg, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
